// File: rtl/led_breath_pwm_pkg.sv
// Shared mode and ramp-state encodings for the LED breathing driver.
package led_pkg;

    localparam logic [1:0] MODE_TRI    = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_HOLD   = 2'd2;
    localparam logic [1:0] MODE_MIRROR = 2'd3;

    typedef enum logic {
        S_UP   = 1'b0,
        S_DOWN = 1'b1
    } ramp_state_e;

endpackage

// File: rtl/led_breath_pwm_tick_div.sv
// Brightness-step prescaler: one-cycle tick every DIV enabled clocks; frozen while en=0.
module led_tick_div #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        presc_d = presc_q;
        if (en) presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
    end

    assign tick = en && (presc_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
    end

endmodule

// File: rtl/led_breath_pwm.sv
// Multi-channel LED breathing driver: prescaled triangle/saw ramp feeding per-channel PWM,
// with optional antiphase drive on odd channels.
module led_breath_pwm
    import led_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int DIV      = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] led_out,
    output logic [WIDTH-1:0]    level,
    output logic                cycle_done
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic                tick;
    ramp_state_e         state_q, state_d;
    logic [WIDTH-1:0]    level_q, level_d;
    logic [WIDTH-1:0]    pwm_q, pwm_d;
    logic                cd_q, cd_d;
    logic [CHANNELS-1:0] led_q, led_d;

    led_tick_div #(.DIV(DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cd_d    = 1'b0;
        if (tick) begin
            case (mode)
                MODE_SAW: begin
                    state_d = S_UP;
                    if (level_q == MAX) begin
                        level_d = '0;
                        cd_d    = 1'b1;
                    end else begin
                        level_d = level_q + 1'b1;
                    end
                end
                MODE_HOLD: begin
                end
                default: begin
                    if (state_q == S_UP) begin
                        // Saw/hold can leave us at MAX in S_UP; turn around instead of wrapping.
                        if (level_q == MAX) begin
                            level_d = level_q - 1'b1;
                            state_d = S_DOWN;
                        end else begin
                            level_d = level_q + 1'b1;
                            if (level_d == MAX) state_d = S_DOWN;
                        end
                    end else begin
                        if (level_q == '0) begin
                            level_d = level_q + 1'b1;
                            state_d = S_UP;
                        end else begin
                            level_d = level_q - 1'b1;
                            if (level_d == '0) begin
                                state_d = S_UP;
                                cd_d    = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign pwm_d = en ? pwm_q + 1'b1 : pwm_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] duty;
        assign duty     = (mode == MODE_MIRROR && (i % 2) == 1) ? MAX - level_q : level_q;
        assign led_d[i] = en && ((duty == MAX) || (pwm_q < duty));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_UP;
            level_q <= '0;
            pwm_q   <= '0;
            cd_q    <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            pwm_q   <= pwm_d;
            cd_q    <= cd_d;
            led_q   <= led_d;
        end
    end

    assign led_out    = led_q;
    assign level      = level_q;
    assign cycle_done = cd_q;

endmodule

// File: tb/tb_led_breath_pwm.sv
// Directed bench for led_breath_pwm at WIDTH=4, CHANNELS=4, DIV=2 (MAX=15).
module tb_led_breath_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] led_out;
    logic [3:0] level;
    logic       cycle_done;

    int errors = 0;
    int checks = 0;
    int ecnt   = 0;   // enabled edges since reset release == expected pwm counter (mod 16)

    led_breath_pwm #(.WIDTH(4), .CHANNELS(4), .DIV(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .led_out    (led_out),
        .level      (level),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic e;
        e = en && !rst;
        @(posedge clk);
        #1;
        if (e) ecnt++;
    endtask

    task automatic until_level(input int tgt, input string tag);
        for (int n = 0; n < 200 && int'(level) != tgt; n++) step();
        chk(tag, level, tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pcb, bad_l, bad_c, bad_d, expv;
        int cnt[4];

        rst = 1'b1; en = 1'b0; mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_led", led_out, 0);
        chk("rst_cd", cycle_done, 0);

        // Triangle: one step per 2 clks, back to 0 with a pulse at clk 60.
        @(negedge clk); rst = 1'b0; en = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            expv = (k / 2 <= 15) ? k / 2 : 30 - k / 2;
            chk("tri_level", level, expv);
            chk("tri_cd", cycle_done, (k == 60) ? 1 : 0);
        end

        // Hold at 0: never on.
        mode = 2'd2;
        bad_d = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (led_out !== 4'h0) bad_d++;
        end
        chk("hold0_led_on_cycles", bad_d, 0);

        // Level 5 held: 5 of 16.
        mode = 2'd0;
        until_level(5, "reach5");
        mode = 2'd2;
        step();
        cnt = '{default: 0};
        for (int k = 0; k < 16; k++) begin
            step();
            for (int c = 0; c < 4; c++) cnt[c] += led_out[c];
        end
        for (int c = 0; c < 4; c++) chk("duty5", cnt[c], 5);
        chk("hold5_level", level, 5);

        // Level 15 held: always on.
        mode = 2'd0;
        until_level(15, "reach15");
        mode = 2'd2;
        step();
        cnt = '{default: 0};
        for (int k = 0; k < 16; k++) begin
            step();
            for (int c = 0; c < 4; c++) cnt[c] += led_out[c];
        end
        for (int c = 0; c < 4; c++) chk("duty15", cnt[c], 16);

        // Mirror descending: at level 4 even channels on for pwm<4, odd for pwm<11.
        mode = 2'd3;
        until_level(4, "mir_reach4");
        for (int k = 0; k < 2; k++) begin
            pcb = ecnt % 16;
            step();
            expv = ((pcb < 11) ? 4'b1010 : 4'b0000) | ((pcb < 4) ? 4'b0101 : 4'b0000);
            chk("mir4_led", led_out, expv);
        end
        until_level(0, "mir_reach0");
        chk("mir0_cd", cycle_done, 1);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("mir0_led", led_out, 4'b1010);
        end

        // Sawtooth: wrap pulse every 32 clks.
        mode = 2'd1;
        for (n = 0; n < 100 && !cycle_done; n++) step();
        chk("saw_cd_seen", cycle_done, 1);
        chk("saw_wrap_level", level, 0);
        n = 0;
        do begin
            step();
            n++;
            if (n == 30) chk("saw_top", level, 15);
        end while (!cycle_done && n < 100);
        chk("saw_period", n, 32);
        chk("saw_wrap_level2", level, 0);

        // Hold at 9 for 100 clks: level fixed, no pulse, 9/16 duty.
        until_level(9, "reach9");
        mode = 2'd2;
        step();
        bad_l = 0; bad_c = 0;
        cnt = '{default: 0};
        for (int k = 0; k < 100; k++) begin
            step();
            if (level !== 4'd9) bad_l++;
            if (cycle_done !== 1'b0) bad_c++;
            if (k < 16) for (int c = 0; c < 4; c++) cnt[c] += led_out[c];
        end
        chk("hold9_level_bad", bad_l, 0);
        chk("hold9_cd_count", bad_c, 0);
        for (int c = 0; c < 4; c++) chk("duty9", cnt[c], 9);

        // en=0 for 37 clks one cycle before a tick; resume must tick on the first edge.
        mode = 2'd0;
        until_level(11, "reach11");
        step();
        en = 1'b0;
        step();
        chk("en0_led", led_out, 0);
        chk("en0_level", level, 11);
        bad_l = 0; bad_d = 0;
        for (int k = 0; k < 36; k++) begin
            step();
            if (level !== 4'd11) bad_l++;
            if (led_out !== 4'h0) bad_d++;
        end
        chk("en0_level_bad", bad_l, 0);
        chk("en0_led_bad", bad_d, 0);
        en = 1'b1;
        pcb = ecnt % 16;
        step();
        chk("resume_level", level, 12);
        chk("resume_led", led_out, (pcb < 11) ? 4'hF : 4'h0);
        step();
        step();
        chk("resume_level2", level, 13);

        // Async reset while descending through 7.
        until_level(15, "reach15b");
        until_level(7, "down7");
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level", level, 0);
        chk("arst_led", led_out, 0);
        chk("arst_cd", cycle_done, 0);
        @(negedge clk); rst = 1'b0; ecnt = 0;
        step();
        chk("post_rst_l0", level, 0);
        step();
        chk("post_rst_l1", level, 1);
        chk("post_rst_cd", cycle_done, 0);
        step();
        step();
        chk("post_rst_l2", level, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
